pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, the maximum number of data-memory wait cycles before abort.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the performance counters.
REQ-003 SHALL have ports, one per line: name, direction, width, meaning.
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- id_ex_memread  in  1  load in ID/EX.
- id_ex_rd  in  5  destination register of ID/EX.
- if_id_rn, if_id_rm  in  5 each  source registers of the instruction in IF/ID.
- ex_mem_branch, ex_mem_uncbranch, ex_mem_zero  in  1 each  branch info in EX/MEM.
- ex_mem_memread, ex_mem_memwrite  in  1 each  memory access in EX/MEM.
- dmem_ready  in  1  data memory completes this cycle.
- pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  stage enables.
- id_ex_bubble, mem_wb_bubble  out  1 each  insert zero control into ID/EX or MEM/WB.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  clear the stage.
- pc_src  out  1  select branch target.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cnt, flush_cnt, wait_cnt  out  CNT_W each  perf counters (REQ-019).

Function
REQ-004 SHALL implement an FSM with the states RUN, MEM_WAIT and FLUSH_SHADOW; outputs are combinational from state and inputs.
REQ-005 SHALL define taken = (ex_mem_branch & ex_mem_zero) | ex_mem_uncbranch.
REQ-006 SHALL define the load-use condition as id_ex_memread & (id_ex_rd != 31) & (id_ex_rd == if_id_rn | id_ex_rd == if_id_rm).
REQ-007 SHALL define the memory-pending condition as (ex_mem_memread | ex_mem_memwrite) & !dmem_ready.
REQ-008 SHALL use this priority: memory-pending > taken > load-use.
REQ-009 SHALL, when memory-pending in RUN or MEM_WAIT:
- drive pc_write, if_id_write, id_ex_write and ex_mem_write to 0;
- drive mem_wb_bubble to 1;
- go to or stay in MEM_WAIT;
- increment a wait counter.
REQ-010 SHALL, in MEM_WAIT, return to RUN on the cycle dmem_ready=1; that cycle behaves as RUN and evaluates taken and load-use.
REQ-011 SHALL, when the wait counter reaches MEM_TIMEOUT, set mem_err and treat the access as complete, as if dmem_ready=1; mem_err clears only on reset.
REQ-012 SHALL clear the wait counter on leaving MEM_WAIT.
REQ-013 SHALL, when taken with no memory pending:
- drive pc_src=1 and if_id_flush=id_ex_flush=ex_mem_flush=1 for exactly that cycle;
- leave all write enables at 1;
- enter FLUSH_SHADOW for one cycle.
REQ-014 SHALL suppress load-use detection in FLUSH_SHADOW, then return to RUN; a taken in FLUSH_SHADOW is honoured per REQ-013.
REQ-015 SHALL, on load-use with no memory pending and no taken, drive pc_write=0, if_id_write=0 and id_ex_bubble=1 for one cycle, remaining in RUN.
REQ-016 SHALL, when idle, drive all write enables to 1 and all flush/bubble signals and pc_src to 0.

Reset
REQ-017 SHALL, on reset assertion, immediately set:
- state to RUN;
- wait counter to 0, mem_err to 0 and the perf counters to 0;
- outputs to the idle values of REQ-016.
REQ-018 SHALL abandon any wait or flush in progress when reset asserts mid-operation, with no pending effect after release.

Configuration
REQ-019 SHALL compile the perf counters in only when PIPE_HAZARD_CTRL_PERF_EN is defined:
- stall_cnt counts load-use stall cycles;
- flush_cnt counts taken events;
- wait_cnt counts MEM_WAIT cycles;
- all three saturate at 2^CNT_W-1.
REQ-020 SHALL tie the three counter outputs to 0 without PIPE_HAZARD_CTRL_PERF_EN and synthesize no counter flops.

Structure
REQ-021 SHALL take the FSM state enum and the constant XZR=5'd31 from the shared package legv8_pipe_pkg.
REQ-022 SHALL implement each perf counter as an instance of the sub-module sat_counter.

Verification
REQ-023 The bench SHALL cover, with PIPE_HAZARD_CTRL_PERF_EN defined unless stated:
- LDUR into X5 followed by an ADD using X5 as rn → exactly 1 cycle of pc_write=0 and id_ex_bubble=1; stall_cnt=1.
- id_ex_rd=31 with memread and matching rn=31 → no stall.
- CBZ taken (branch=1, zero=1) → a single-cycle pc_src=1 with all three flushes; next cycle is FLUSH_SHADOW with load-use ignored; flush_cnt=1.
- memread with dmem_ready low for 3 cycles → 3 cycles with all write enables 0 and mem_wb_bubble=1, resuming on cycle 4; wait_cnt=3.
- dmem_ready stuck low → mem_err=1 after 15 wait cycles and the pipeline resumes; a reset asserted during MEM_WAIT returns to idle outputs immediately.
- Build without the macro → counters read 0 after the scenarios above.

Source files
------------

// File: rtl/legv8_pipe_pkg.sv
// Shared LEGv8 pipeline definitions: hazard-controller FSM states and the zero register index.
package legv8_pipe_pkg;

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StFlushShadow
  } hz_state_e;

  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the LEGv8 pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_ex_memread;
  logic [4:0]       id_ex_rd;
  logic [4:0]       if_id_rn;
  logic [4:0]       if_id_rm;
  logic             ex_mem_branch;
  logic             ex_mem_uncbranch;
  logic             ex_mem_zero;
  logic             ex_mem_memread;
  logic             ex_mem_memwrite;
  logic             dmem_ready;

  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             id_ex_bubble;
  logic             mem_wb_bubble;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             pc_src;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_cnt;

  modport master (
    output id_ex_memread, id_ex_rd, if_id_rn, if_id_rm, ex_mem_branch, ex_mem_uncbranch,
           ex_mem_zero, ex_mem_memread, ex_mem_memwrite, dmem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble, mem_wb_bubble,
           if_id_flush, id_ex_flush, ex_mem_flush, pc_src, mem_err, stall_cnt, flush_cnt,
           wait_cnt
  );

  modport slave (
    input  id_ex_memread, id_ex_rd, if_id_rn, if_id_rm, ex_mem_branch, ex_mem_uncbranch,
           ex_mem_zero, ex_mem_memread, ex_mem_memwrite, dmem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble, mem_wb_bubble,
           if_id_flush, id_ex_flush, ex_mem_flush, pc_src, mem_err, stall_cnt, flush_cnt,
           wait_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// LEGv8 pipeline hazard controller: memory waits, branch flushes and load-use stalls.
// Perf counters are built only when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
  import legv8_pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clock,
  input  logic                reset,
  pipe_hazard_ctrl_if.slave   hz
);

  localparam int unsigned WaitW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] TimeoutVal = WaitW'(MEM_TIMEOUT);

  hz_state_e        state_q, state_d;
  logic [WaitW-1:0] wcnt_q, wcnt_d;
  logic             mem_err_q;

  logic taken, load_use, mem_access, timeout, mem_pend, do_flush, do_stall;

  assign taken      = (hz.ex_mem_branch & hz.ex_mem_zero) | hz.ex_mem_uncbranch;
  assign load_use   = hz.id_ex_memread & (hz.id_ex_rd != XZR) &
                      ((hz.id_ex_rd == hz.if_id_rn) | (hz.id_ex_rd == hz.if_id_rm));
  assign mem_access = hz.ex_mem_memread | hz.ex_mem_memwrite;
  // A timed-out access is retired exactly as if dmem_ready had arrived.
  assign timeout    = mem_access & ~hz.dmem_ready & (wcnt_q == TimeoutVal);
  assign mem_pend   = mem_access & ~hz.dmem_ready & ~timeout;
  assign do_flush   = ~mem_pend & taken;
  assign do_stall   = ~mem_pend & ~taken & load_use & (state_q != StFlushShadow);

  always_comb begin
    state_d = StRun;
    wcnt_d  = '0;
    if (mem_pend) begin
      state_d = StMemWait;
      wcnt_d  = wcnt_q + 1'b1;
    end else if (taken) begin
      state_d = StFlushShadow;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StRun;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_q | timeout;
    end
  end

  // Outputs are held at idle values while reset is asserted, whatever the inputs say.
  always_comb begin
    hz.pc_write      = 1'b1;
    hz.if_id_write   = 1'b1;
    hz.id_ex_write   = 1'b1;
    hz.ex_mem_write  = 1'b1;
    hz.id_ex_bubble  = 1'b0;
    hz.mem_wb_bubble = 1'b0;
    hz.if_id_flush   = 1'b0;
    hz.id_ex_flush   = 1'b0;
    hz.ex_mem_flush  = 1'b0;
    hz.pc_src        = 1'b0;
    if (!reset) begin
      if (mem_pend) begin
        hz.pc_write      = 1'b0;
        hz.if_id_write   = 1'b0;
        hz.id_ex_write   = 1'b0;
        hz.ex_mem_write  = 1'b0;
        hz.mem_wb_bubble = 1'b1;
      end else if (do_flush) begin
        hz.pc_src       = 1'b1;
        hz.if_id_flush  = 1'b1;
        hz.id_ex_flush  = 1'b1;
        hz.ex_mem_flush = 1'b1;
      end else if (do_stall) begin
        hz.pc_write     = 1'b0;
        hz.if_id_write  = 1'b0;
        hz.id_ex_bubble = 1'b1;
      end
    end
  end

  assign hz.mem_err = mem_err_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (do_stall),
    .cnt   (hz.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (do_flush),
    .cnt   (hz.flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (mem_pend),
    .cnt   (hz.wait_cnt)
  );
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
  assign hz.wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed cycles push expectations, a negedge monitor
// pops and compares. Counter expectations collapse to 0 when PIPE_HAZARD_CTRL_PERF_EN is unset.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CW = 16;

  // {pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble, mem_wb_bubble,
  //  if_id_flush, id_ex_flush, ex_mem_flush, pc_src, mem_err}
  localparam logic [10:0] IDLE  = 11'b1111_00_000_0_0;
  localparam logic [10:0] STALL = 11'b0011_10_000_0_0;
  localparam logic [10:0] TAKEN = 11'b1111_00_111_1_0;
  localparam logic [10:0] MWAIT = 11'b0000_01_000_0_0;
  localparam logic [10:0] ERR   = 11'b0000_00_000_0_1;

  typedef struct {
    string       name;
    logic [10:0] ctl;
    int          s;
    int          f;
    int          w;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .hz    (bus)
  );

  function automatic int ce(input int v);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic cyc(input string nm, input logic r, input logic mr, input logic [4:0] rd,
                     input logic [4:0] rn, input logic [4:0] rm, input logic br,
                     input logic un, input logic zr, input logic emr, input logic emw,
                     input logic rdy, input logic [10:0] ctl, input int s, input int f,
                     input int w);
    @(posedge clock);
    #1;
    reset                = r;
    bus.id_ex_memread    = mr;
    bus.id_ex_rd         = rd;
    bus.if_id_rn         = rn;
    bus.if_id_rm         = rm;
    bus.ex_mem_branch    = br;
    bus.ex_mem_uncbranch = un;
    bus.ex_mem_zero      = zr;
    bus.ex_mem_memread   = emr;
    bus.ex_mem_memwrite  = emw;
    bus.dmem_ready       = rdy;
    exp_q.push_back('{name: nm, ctl: ctl, s: ce(s), f: ce(f), w: ce(w)});
  endtask

  always @(negedge clock) begin
    exp_t        e;
    logic [10:0] act;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      act = {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write,
             bus.id_ex_bubble, bus.mem_wb_bubble, bus.if_id_flush, bus.id_ex_flush,
             bus.ex_mem_flush, bus.pc_src, bus.mem_err};
      tests++;
      if (act !== e.ctl) begin
        fails++;
        $display("FAIL %s ctl: got %b want %b", e.name, act, e.ctl);
      end
      tests++;
      if (bus.stall_cnt !== CW'(e.s) || bus.flush_cnt !== CW'(e.f) ||
          bus.wait_cnt !== CW'(e.w)) begin
        fails++;
        $display("FAIL %s counters: got s=%0d f=%0d w=%0d want s=%0d f=%0d w=%0d", e.name,
                 bus.stall_cnt, bus.flush_cnt, bus.wait_cnt, e.s, e.f, e.w);
      end
    end
  end

  initial begin
    bus.id_ex_memread    = 1'b0;
    bus.id_ex_rd         = '0;
    bus.if_id_rn         = '0;
    bus.if_id_rm         = '0;
    bus.ex_mem_branch    = 1'b0;
    bus.ex_mem_uncbranch = 1'b0;
    bus.ex_mem_zero      = 1'b0;
    bus.ex_mem_memread   = 1'b0;
    bus.ex_mem_memwrite  = 1'b0;
    bus.dmem_ready       = 1'b1;
    repeat (2) @(posedge clock);

    //   name               r  mr rd  rn  rm br un zr emr emw rdy ctl        s  f  w
    cyc("reset_idle",       1, 0, 0,  0,  0, 0, 0, 0, 0,  0,  1,  IDLE,      0, 0, 0);
    cyc("ldur_add_stall",   0, 1, 5,  5,  0, 0, 0, 0, 0,  0,  1,  STALL,     0, 0, 0);
    cyc("stall_one_cycle",  0, 0, 5,  5,  0, 0, 0, 0, 0,  0,  1,  IDLE,      1, 0, 0);
    cyc("xzr_no_stall",     0, 1, 31, 31, 31, 0, 0, 0, 0, 0,  1,  IDLE,      1, 0, 0);
    cyc("cbz_taken",        0, 0, 0,  0,  0, 1, 0, 1, 0,  0,  1,  TAKEN,     1, 0, 0);
    cyc("shadow_no_lu",     0, 1, 7,  7,  0, 0, 0, 0, 0,  0,  1,  IDLE,      1, 1, 0);
    cyc("lu_after_shadow",  0, 1, 7,  0,  7, 0, 0, 0, 0,  0,  1,  STALL,     1, 1, 0);
    cyc("cbz_not_taken",    0, 0, 0,  0,  0, 1, 0, 0, 0,  0,  1,  IDLE,      2, 1, 0);
    cyc("b_uncond",         0, 0, 0,  0,  0, 0, 1, 0, 0,  0,  1,  TAKEN,     2, 1, 0);
    cyc("shadow_idle",      0, 0, 0,  0,  0, 0, 0, 0, 0,  0,  1,  IDLE,      2, 2, 0);
    cyc("mem_over_all",     0, 1, 5,  5,  0, 1, 0, 1, 1,  0,  0,  MWAIT,     2, 2, 0);
    cyc("mem_wait2",        0, 0, 0,  0,  0, 0, 0, 0, 1,  0,  0,  MWAIT,     2, 2, 1);
    cyc("mem_wait3",        0, 0, 0,  0,  0, 0, 0, 0, 1,  0,  0,  MWAIT,     2, 2, 2);
    cyc("mem_done_taken",   0, 0, 0,  0,  0, 1, 0, 1, 1,  0,  1,  TAKEN,     2, 2, 3);
    cyc("shadow_after_mem", 0, 0, 0,  0,  0, 0, 0, 0, 0,  0,  1,  IDLE,      2, 3, 3);
    for (int i = 0; i < 15; i++) begin
      cyc("timeout_wait",   0, 0, 0,  0,  0, 0, 0, 0, 1,  0,  0,  MWAIT,     2, 3, 3 + i);
    end
    cyc("timeout_resume",   0, 0, 0,  0,  0, 0, 0, 0, 1,  0,  0,  IDLE,      2, 3, 18);
    cyc("mem_err_sticky",   0, 0, 0,  0,  0, 0, 0, 0, 0,  0,  1,  IDLE | ERR, 2, 3, 18);
    cyc("lu_after_err",     0, 1, 9,  0,  9, 0, 0, 0, 0,  0,  1,  STALL | ERR, 2, 3, 18);
    cyc("idle_after_err",   0, 0, 0,  0,  0, 0, 0, 0, 0,  0,  1,  IDLE | ERR, 3, 3, 18);
    cyc("wait_before_rst",  0, 0, 0,  0,  0, 0, 0, 0, 0,  1,  0,  MWAIT | ERR, 3, 3, 18);
    cyc("rst_mid_wait",     1, 0, 0,  0,  0, 0, 0, 0, 0,  1,  0,  IDLE,      0, 0, 0);
    cyc("post_rst_idle",    0, 0, 0,  0,  0, 0, 0, 0, 0,  0,  1,  IDLE,      0, 0, 0);
    cyc("post_rst_wait",    0, 0, 0,  0,  0, 0, 0, 0, 1,  0,  0,  MWAIT,     0, 0, 0);
    cyc("post_rst_done",    0, 0, 0,  0,  0, 0, 0, 0, 1,  0,  1,  IDLE,      0, 0, 1);

    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
